// File: rtl/proc_pkg.sv
// Shared definitions for the processor memory unit: FSM encoding, width defaults
// and a clog2 helper that never returns a zero-width result.
package proc_pkg;

  localparam int unsigned DefDataW     = 16;
  localparam int unsigned DefAddrW     = 16;
  localparam int unsigned DefDataDepth = 256;
  localparam int unsigned DefProgAw    = 6;
  localparam int unsigned DefNumProgs  = 2;

  typedef enum logic [0:0] {
    StIdle,
    StRun
  } state_e;

  // Index width for n entries; at least 1 bit so single-entry cases stay legal.
  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/proc_ram.sv
// Simple dual-port RAM: one synchronous write port, one registered read port.
// Array contents survive reset; only the read register is cleared.
module proc_ram #(
  parameter int unsigned Width = 16,
  parameter int unsigned Depth = 256,
  parameter int unsigned AddrW = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             we_i,
  input  logic [AddrW-1:0] waddr_i,
  input  logic [Width-1:0] wdata_i,
  input  logic             re_i,
  input  logic [AddrW-1:0] raddr_i,
  output logic [Width-1:0] rdata_o
);

  logic [Width-1:0] mem_q [Depth];
  logic [Width-1:0] rdata_q;

  // Storage array write; no reset so contents are retained across resets.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Registered read; same-edge write is not visible (read-before-write).
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/proc_mem_unit.sv
// Processor-side memory unit: banked program memory with a run/idle FSM that
// latches the active bank, plus a data memory with edge-committed stores,
// registered loads, a sticky range-error flag and a saturating store counter.
module proc_mem_unit
  import proc_pkg::*;
#(
  parameter int unsigned DATA_W     = DefDataW,
  parameter int unsigned ADDR_W     = DefAddrW,
  parameter int unsigned DATA_DEPTH = DefDataDepth,
  parameter int unsigned PROG_AW    = DefProgAw,
  parameter int unsigned NUM_PROGS  = DefNumProgs
) (
  input  logic                               clk_i,
  input  logic                               rst_ni,
  input  logic                               run_i,
  input  logic                               done_i,
  input  logic [clog2_min1(NUM_PROGS)-1:0]   prog_sel_i,
  input  logic                               prog_wr_i,
  input  logic [clog2_min1(NUM_PROGS)-1:0]   prog_bank_i,
  input  logic [PROG_AW-1:0]                 prog_addr_i,
  input  logic [DATA_W-1:0]                  prog_data_i,
  input  logic [PROG_AW-1:0]                 fetch_addr_i,
  output logic [DATA_W-1:0]                  instr_o,
  input  logic [ADDR_W-1:0]                  addr_i,
  input  logic [DATA_W-1:0]                  wdata_i,
  input  logic                               store_i,
  input  logic                               load_i,
  output logic [DATA_W-1:0]                  rdata_o,
  output logic                               rvalid_o,
  output logic                               busy_o,
  output logic [clog2_min1(NUM_PROGS)-1:0]   active_bank_o,
  output logic                               addr_err_o,
  output logic [15:0]                        store_count_o
);

  localparam int unsigned BankW    = clog2_min1(NUM_PROGS);
  localparam int unsigned DataAw   = clog2_min1(DATA_DEPTH);
  localparam int unsigned ProgDepth = 2 ** PROG_AW;
  localparam logic [BankW-1:0]  MaxBank = BankW'(NUM_PROGS - 1);
  // One extra bit so DATA_DEPTH == 2**ADDR_W does not wrap to zero.
  localparam logic [ADDR_W:0]   DepthL  = (ADDR_W + 1)'(DATA_DEPTH);

  state_e             state_q, state_d;
  logic               start;
  logic [BankW-1:0]   active_bank_q, active_bank_d;
  logic [BankW-1:0]   rd_bank_q;
  logic               store_q;
  logic               rvalid_q;
  logic               load_oor_q, load_oor_d;
  logic               err_q, err_d;
  logic [15:0]        count_q, count_d;
  logic [15:0]        count_base;

  logic               addr_in_range;
  logic               store_commit;
  logic               data_we;
  logic               data_re;
  logic               oor_access;
  logic               prog_wr_ok;
  logic [DATA_W-1:0]  data_rdata;
  logic [DATA_W-1:0]  bank_rdata [NUM_PROGS];

  // Run/idle next state; start marks the IDLE -> RUN transition.
  always_comb begin
    state_d = state_q;
    start   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (run_i) begin
          state_d = StRun;
          start   = 1'b1;
        end
      end
      StRun: begin
        if (done_i || !run_i) begin
          state_d = StIdle;
        end
      end
    endcase
  end

  // Data-side decode, bank latch, sticky error and store counter next state.
  always_comb begin
    addr_in_range = ({1'b0, addr_i} < DepthL);
    store_commit  = store_i && !store_q;
    data_we       = store_commit && addr_in_range;
    data_re       = load_i && addr_in_range;
    oor_access    = (store_commit || load_i) && !addr_in_range;
    load_oor_d    = load_i ? !addr_in_range : load_oor_q;

    active_bank_d = active_bank_q;
    if (start) begin
      active_bank_d = (prog_sel_i > MaxBank) ? MaxBank : prog_sel_i;
    end

    // A new run clears history first, so an access in the start cycle still counts.
    err_d      = (start ? 1'b0 : err_q) | oor_access;
    count_base = start ? 16'h0000 : count_q;
    count_d    = (data_we && count_base != 16'hFFFF) ? count_base + 16'h0001 : count_base;

    prog_wr_ok = prog_wr_i && (state_q == StIdle) && (prog_bank_i <= MaxBank);
  end

  // Control state registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= StIdle;
      active_bank_q <= '0;
      rd_bank_q     <= '0;
      store_q       <= 1'b0;
      rvalid_q      <= 1'b0;
      load_oor_q    <= 1'b0;
      err_q         <= 1'b0;
      count_q       <= '0;
    end else begin
      state_q       <= state_d;
      active_bank_q <= active_bank_d;
      // Bank used for the fetch sampled this edge, aligned with the RAM read latency.
      rd_bank_q     <= active_bank_q;
      store_q       <= store_i;
      rvalid_q      <= load_i;
      load_oor_q    <= load_oor_d;
      err_q         <= err_d;
      count_q       <= count_d;
    end
  end

  proc_ram #(
    .Width (DATA_W),
    .Depth (DATA_DEPTH),
    .AddrW (DataAw)
  ) u_data_ram (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .we_i    (data_we),
    .waddr_i (addr_i[DataAw-1:0]),
    .wdata_i (wdata_i),
    .re_i    (data_re),
    .raddr_i (addr_i[DataAw-1:0]),
    .rdata_o (data_rdata)
  );

  for (genvar b = 0; b < NUM_PROGS; b++) begin : g_bank
    proc_ram #(
      .Width (DATA_W),
      .Depth (ProgDepth),
      .AddrW (PROG_AW)
    ) u_prog_ram (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .we_i    (prog_wr_ok && (prog_bank_i == BankW'(b))),
      .waddr_i (prog_addr_i),
      .wdata_i (prog_data_i),
      .re_i    (1'b1),
      .raddr_i (fetch_addr_i),
      .rdata_o (bank_rdata[b])
    );
  end

  assign instr_o       = bank_rdata[rd_bank_q];
  assign rdata_o       = load_oor_q ? '0 : data_rdata;
  assign rvalid_o      = rvalid_q;
  assign busy_o        = (state_q == StRun);
  assign active_bank_o = active_bank_q;
  assign addr_err_o    = err_q;
  assign store_count_o = count_q;

endmodule

// File: tb/tb_proc_mem_unit.sv
// Directed bench for proc_mem_unit with default parameters.
module tb_proc_mem_unit;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        run_i, done_i;
  logic [0:0]  prog_sel_i, prog_bank_i;
  logic        prog_wr_i;
  logic [5:0]  prog_addr_i, fetch_addr_i;
  logic [15:0] prog_data_i;
  logic [15:0] instr_o;
  logic [15:0] addr_i, wdata_i;
  logic        store_i, load_i;
  logic [15:0] rdata_o;
  logic        rvalid_o, busy_o;
  logic [0:0]  active_bank_o;
  logic        addr_err_o;
  logic [15:0] store_count_o;

  int checks = 0;
  int failures = 0;

  proc_mem_unit dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .run_i         (run_i),
    .done_i        (done_i),
    .prog_sel_i    (prog_sel_i),
    .prog_wr_i     (prog_wr_i),
    .prog_bank_i   (prog_bank_i),
    .prog_addr_i   (prog_addr_i),
    .prog_data_i   (prog_data_i),
    .fetch_addr_i  (fetch_addr_i),
    .instr_o       (instr_o),
    .addr_i        (addr_i),
    .wdata_i       (wdata_i),
    .store_i       (store_i),
    .load_i        (load_i),
    .rdata_o       (rdata_o),
    .rvalid_o      (rvalid_o),
    .busy_o        (busy_o),
    .active_bank_o (active_bank_o),
    .addr_err_o    (addr_err_o),
    .store_count_o (store_count_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_ni = 1'b0; run_i = 0; done_i = 0; prog_sel_i = 0; prog_bank_i = 0;
    prog_wr_i = 0; prog_addr_i = 0; prog_data_i = 0; fetch_addr_i = 0;
    addr_i = 0; wdata_i = 0; store_i = 0; load_i = 0;
    #2;
    chk("rst_instr", 32'(instr_o), 32'h0);
    chk("rst_rdata", 32'(rdata_o), 32'h0);
    chk("rst_rvalid", 32'(rvalid_o), 32'h0);
    chk("rst_busy", 32'(busy_o), 32'h0);
    chk("rst_bank", 32'(active_bank_o), 32'h0);
    chk("rst_err", 32'(addr_err_o), 32'h0);
    chk("rst_count", 32'(store_count_o), 32'h0);
    #10 rst_ni = 1'b1;

    // Program load in IDLE
    prog_wr_i = 1; prog_bank_i = 0; prog_addr_i = 0; prog_data_i = 16'h00A5; tick();
    prog_bank_i = 1; prog_data_i = 16'h0021; tick();
    prog_wr_i = 0; fetch_addr_i = 0; tick();
    chk("idle_fetch_bank0", 32'(instr_o), 32'h00A5);

    // Start run on bank 1
    prog_sel_i = 1; run_i = 1; tick();
    chk("run_busy", 32'(busy_o), 32'h1);
    chk("run_bank", 32'(active_bank_o), 32'h1);
    tick();
    chk("run_instr_bank1", 32'(instr_o), 32'h0021);

    // Program write and bank select ignored during RUN
    prog_wr_i = 1; prog_bank_i = 1; prog_addr_i = 0; prog_data_i = 16'hBEEF; prog_sel_i = 0;
    tick();
    prog_wr_i = 0;
    chk("run_sel_ignored", 32'(active_bank_o), 32'h1);
    tick();
    chk("run_progwr_ignored", 32'(instr_o), 32'h0021);

    // Store held high commits once
    addr_i = 3; wdata_i = 16'h0004; store_i = 1;
    repeat (5) tick();
    chk("held_store_count", 32'(store_count_o), 32'h1);
    store_i = 0; load_i = 1; tick();
    chk("load3_data", 32'(rdata_o), 32'h0004);
    chk("load3_valid", 32'(rvalid_o), 32'h1);
    load_i = 0; tick();
    chk("load3_valid_drop", 32'(rvalid_o), 32'h0);

    // Read-before-write on same address
    addr_i = 5; wdata_i = 16'h1111; store_i = 1; tick();
    store_i = 0; tick();
    wdata_i = 16'h2222; store_i = 1; load_i = 1; tick();
    chk("rbw_old", 32'(rdata_o), 32'h1111);
    chk("rbw_count", 32'(store_count_o), 32'h3);
    store_i = 0; tick();
    chk("rbw_new", 32'(rdata_o), 32'h2222);
    addr_i = 3; tick();
    chk("load_back2back", 32'(rdata_o), 32'h0004);
    chk("load_back2back_v", 32'(rvalid_o), 32'h1);
    load_i = 0; tick();

    // Out-of-range store/load
    addr_i = 44; wdata_i = 16'h0044; store_i = 1; tick();
    store_i = 0; tick();
    addr_i = 300; wdata_i = 16'hDEAD; store_i = 1; tick();
    chk("oor_err", 32'(addr_err_o), 32'h1);
    chk("oor_count", 32'(store_count_o), 32'h4);
    store_i = 0; load_i = 1; tick();
    chk("oor_load_zero", 32'(rdata_o), 32'h0);
    chk("oor_load_valid", 32'(rvalid_o), 32'h1);
    addr_i = 44; tick();
    chk("oor_no_alias", 32'(rdata_o), 32'h0044);
    load_i = 0;

    // Done ends the run; error stays sticky in IDLE
    done_i = 1; tick();
    chk("done_idle", 32'(busy_o), 32'h0);
    done_i = 0; run_i = 0; tick();
    chk("err_sticky", 32'(addr_err_o), 32'h1);

    // Stores honoured in IDLE
    addr_i = 7; wdata_i = 16'h0777; store_i = 1; tick();
    chk("idle_store_count", 32'(store_count_o), 32'h5);
    store_i = 0; tick();

    // New run clears error and counter
    prog_sel_i = 0; run_i = 1; tick();
    chk("newrun_err", 32'(addr_err_o), 32'h0);
    chk("newrun_count", 32'(store_count_o), 32'h0);
    chk("newrun_bank", 32'(active_bank_o), 32'h0);
    tick();
    chk("newrun_instr", 32'(instr_o), 32'h00A5);

    // Run drop coincident with a store edge still commits
    run_i = 0; addr_i = 9; wdata_i = 16'h0999; store_i = 1; tick();
    chk("exit_busy", 32'(busy_o), 32'h0);
    chk("exit_store_count", 32'(store_count_o), 32'h1);
    store_i = 0; load_i = 1; tick();
    chk("exit_store_data", 32'(rdata_o), 32'h0999);

    // Reset mid-run with a load in flight
    run_i = 1; addr_i = 3; tick();
    chk("pre_rst_valid", 32'(rvalid_o), 32'h1);
    #2 rst_ni = 1'b0;
    #1;
    chk("mid_rst_rdata", 32'(rdata_o), 32'h0);
    chk("mid_rst_rvalid", 32'(rvalid_o), 32'h0);
    chk("mid_rst_busy", 32'(busy_o), 32'h0);
    chk("mid_rst_instr", 32'(instr_o), 32'h0);
    chk("mid_rst_count", 32'(store_count_o), 32'h0);
    #2 rst_ni = 1'b1;
    run_i = 0; tick();
    chk("post_rst_mem3", 32'(rdata_o), 32'h0004);
    addr_i = 7; tick();
    chk("post_rst_mem7", 32'(rdata_o), 32'h0777);
    load_i = 0; tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
